lcm_calculator: RTL

//  Sequential least-common-multiple engine, the companion to the GCD unit.

---
 rtl/lcm_calculator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lcm_calculator.sv
// Sequential LCM engine: Euclid gcd, restoring divide x/g, shift-add multiply by y.
// Optional build macro LCM_GCD_OUT_EN adds a registered gcd_o output.
module lcm_calculator #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] lcm
`ifdef LCM_GCD_OUT_EN
    ,
    output logic [WIDTH-1:0]   gcd_o
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EUCLID,
        S_DIVIDE,
        S_MULT,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] lcm_q, lcm_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   g_q, g_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
`ifdef LCM_GCD_OUT_EN
    logic [WIDTH-1:0]   gcd_q, gcd_d;
`endif

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   quo_sh;
    logic               last_bit;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        lcm_d    = lcm_q;
        x_d      = x_q;
        y_d      = y_q;
        a_d      = a_q;
        b_d      = b_q;
        g_d      = g_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        p_d      = p_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`ifdef LCM_GCD_OUT_EN
        gcd_d    = gcd_q;
`endif
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        quo_sh   = {quo_q[WIDTH-2:0], 1'b0};
        last_bit = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = x;
                    y_d    = y;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (x == '0 || y == '0) begin
                        g_d     = x | y;
                        p_d     = '0;
                        state_d = S_FINISH;
                    end else begin
                        a_d     = (x > y) ? x : y;
                        b_d     = (x > y) ? y : x;
                        state_d = S_EUCLID;
                    end
                end
            end
            S_EUCLID: begin
                if (b_q == '0) begin
                    g_d     = a_q;
                    rem_d   = '0;
                    quo_d   = x_q;
                    cnt_d   = '0;
                    state_d = S_DIVIDE;
                end else begin
                    a_d = b_q;
                    b_d = a_q % b_q;
                end
            end
            S_DIVIDE: begin
                // Dividend bits shift out of quo_q while quotient bits shift in.
                if (rem_sh >= {1'b0, g_q}) begin
                    rem_sh    = rem_sh - {1'b0, g_q};
                    quo_sh[0] = 1'b1;
                end
                rem_d = rem_sh[WIDTH-1:0];
                quo_d = quo_sh;
                cnt_d = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d    = '0;
                    p_d      = '0;
                    mcand_d  = {{WIDTH{1'b0}}, quo_sh};
                    mplier_d = y_q;
                    state_d  = S_MULT;
                end
            end
            S_MULT: begin
                if (mplier_q[0]) p_d = p_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                lcm_d   = p_q;
`ifdef LCM_GCD_OUT_EN
                gcd_d   = g_q;
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lcm_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            g_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            p_q      <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`ifdef LCM_GCD_OUT_EN
            gcd_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lcm_q    <= lcm_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a_q      <= a_d;
            b_q      <= b_d;
            g_q      <= g_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            p_q      <= p_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`ifdef LCM_GCD_OUT_EN
            gcd_q    <= gcd_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lcm  = lcm_q;
`ifdef LCM_GCD_OUT_EN
    assign gcd_o = gcd_q;
`endif

endmodule
